ch0_mod_copy: RTL and testbench

//  Module-side client of a DMA channel buffer: pops 64-bit words from the channel src FIFO
//  (m_src_*), optionally inverts them, and pushes them into the channel dst FIFO (m_dst_*).
//  It forwards the last flag, counts words and bounds the transfer length.
//  It sits between the channel buffer and the block's control registers, and drives the

---
 rtl/ch0_mod_copy.sv | 135 +++++++++++++
 tb/tb_ch0_mod_copy.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ch0_mod_copy.sv
// ch0_mod_copy: DMA channel module-side copy client (src FIFO -> optional invert -> dst FIFO)
//   Clock/reset : wb_clk_i, wb_rst_n_i (async, active-low)
//   Control     : start, abort, inv, max_words -> busy, done, ovf, word_cnt
//   Channel     : m_reset0 FIFO clear; src pop (m_src_getn0/m_src0/m_src_last0/m_src_empty0/
//                 m_src_almost_empty0); dst push (m_dst_putn0/m_dst0/m_dst_last0/m_dst_full0/
//                 m_dst_almost_full0)
//   Option      : MCOPY_CHKSUM_EN adds chksum (XOR of pushed words) and burst-preserving pops
module ch0_mod_copy #(
  parameter int CNT_W  = 16,
  parameter int DATA_W = 64
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              start,
  input  logic              abort,
  input  logic              inv,
  input  logic [CNT_W-1:0]  max_words,
  output logic              busy,
  output logic              done,
  output logic              ovf,
  output logic [CNT_W-1:0]  word_cnt,
  output logic              m_reset0,
  output logic              m_src_getn0,
  input  logic [DATA_W-1:0] m_src0,
  input  logic              m_src_last0,
  input  logic              m_src_empty0,
  input  logic              m_src_almost_empty0,
  output logic              m_dst_putn0,
  output logic [DATA_W-1:0] m_dst0,
  output logic              m_dst_last0,
  input  logic              m_dst_full0,
  input  logic              m_dst_almost_full0
`ifdef MCOPY_CHKSUM_EN
  , output logic [DATA_W-1:0] chksum
`endif
);
  typedef enum logic [2:0] {IDLE, CLR, RD, LAT, WR, DONE} state_t;
  state_t             state_q, state_d;
  logic               inv_q, inv_d;
  logic [CNT_W-1:0]   limit_q, limit_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               rst_q, rst_d;
  logic [DATA_W-1:0]  hold_q, hold_d;
  logic               hold_last_q, hold_last_d;
  logic               lim, rd_ok, pop, push;
  logic               unused_ok;
  assign unused_ok = &{1'b0, m_dst_almost_full0, m_src_almost_empty0};
  assign lim = (cnt_q + CNT_W'(1)) == limit_q;
`ifdef MCOPY_CHKSUM_EN
  // Only start a pop when a whole burst is available or its last word is at the head
  assign rd_ok = !m_src_empty0 && !m_dst_full0 && (!m_src_almost_empty0 || m_src_last0);
`else
  assign rd_ok = !m_src_empty0 && !m_dst_full0;
`endif
  // abort suppresses any pop/push in its own cycle
  assign pop  = (state_q == RD) && rd_ok && !abort;
  assign push = (state_q == WR) && !m_dst_full0 && !abort;
  always_comb begin
    state_d     = state_q;
    inv_d       = inv_q;
    limit_d     = limit_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    hold_d      = hold_q;
    hold_last_d = hold_last_q;
    rst_d       = abort;
    if (abort) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: if (start) begin
          state_d = CLR;
          inv_d   = inv;
          limit_d = (max_words == '0) ? '1 : max_words;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
        CLR:  state_d = RD;
        RD:   state_d = pop ? LAT : RD;
        LAT: begin
          hold_d      = inv_q ? ~m_src0 : m_src0;
          hold_last_d = m_src_last0;
          state_d     = WR;
        end
        WR: if (push) begin
          cnt_d   = cnt_q + CNT_W'(1);
          ovf_d   = ovf_q | (lim & ~hold_last_q);
          state_d = (hold_last_q | lim) ? DONE : RD;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q     <= IDLE;
      inv_q       <= 1'b0;
      limit_q     <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      rst_q       <= 1'b0;
      hold_q      <= '0;
      hold_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      inv_q       <= inv_d;
      limit_q     <= limit_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      rst_q       <= rst_d;
      hold_q      <= hold_d;
      hold_last_q <= hold_last_d;
    end
  end
`ifdef MCOPY_CHKSUM_EN
  logic [DATA_W-1:0] chksum_q, chksum_d;
  assign chksum_d = (state_q == CLR) ? '0 : push ? (chksum_q ^ hold_q) : chksum_q;
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) chksum_q <= '0;
    else chksum_q <= chksum_d;
  end
  assign chksum = chksum_q;
`endif
  assign busy        = state_q != IDLE;
  assign done        = state_q == DONE;
  assign ovf         = ovf_q;
  assign word_cnt    = cnt_q;
  // CLR gives the start-of-transfer clear; rst_q gives the post-abort clear
  assign m_reset0    = (state_q == CLR) | rst_q;
  assign m_src_getn0 = ~pop;
  assign m_dst_putn0 = ~push;
  assign m_dst0      = hold_q;
  assign m_dst_last0 = (state_q == WR) & (hold_last_q | lim);
endmodule

// File: tb/tb_ch0_mod_copy.sv
// tb_ch0_mod_copy: scoreboard bench for ch0_mod_copy with FIFO models and a transfer-level reference
module tb_ch0_mod_copy;
  localparam int CNT_W  = 16;
  localparam int DATA_W = 64;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic start = 0, abort = 0, inv = 0;
  logic [CNT_W-1:0] max_words = '0;
  logic busy, done, ovf, m_reset0, m_src_getn0, m_dst_putn0, m_dst_last0;
  logic [CNT_W-1:0] word_cnt;
  logic [DATA_W-1:0] m_src0 = '0, m_dst0;
  logic m_src_last0 = 0, m_src_empty0 = 1, m_src_almost_empty0 = 0;
  logic m_dst_full0 = 0, m_dst_almost_full0 = 0;
`ifdef MCOPY_CHKSUM_EN
  logic [DATA_W-1:0] chksum;
`endif
  ch0_mod_copy #(.CNT_W(CNT_W), .DATA_W(DATA_W)) dut (
`ifdef MCOPY_CHKSUM_EN
    .chksum(chksum),
`endif
    .wb_clk_i(clk), .wb_rst_n_i(rst_n), .start(start), .abort(abort), .inv(inv),
    .max_words(max_words), .busy(busy), .done(done), .ovf(ovf), .word_cnt(word_cnt),
    .m_reset0(m_reset0), .m_src_getn0(m_src_getn0), .m_src0(m_src0), .m_src_last0(m_src_last0),
    .m_src_empty0(m_src_empty0), .m_src_almost_empty0(m_src_almost_empty0),
    .m_dst_putn0(m_dst_putn0), .m_dst0(m_dst0), .m_dst_last0(m_dst_last0),
    .m_dst_full0(m_dst_full0), .m_dst_almost_full0(m_dst_almost_full0));
  int checks = 0, errors = 0, pops = 0, dones = 0;
  logic [DATA_W:0] srcq[$], stim_q[$], expq[$];
  logic [CNT_W:0] doneq[$];
  logic sg = 1, sr = 0, full_force = 0, stall_en = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask
  // src FIFO: read data appears the cycle after a pop; m_reset0 empties it
  always @(posedge clk) begin
    #1;
    if (sr) srcq.delete();
    else if (!sg && srcq.size() > 0) {m_src_last0, m_src0} = srcq.pop_front();
    m_src_empty0 = srcq.size() == 0;
  end
  always @(posedge clk) begin
    #2;
    m_dst_full0 = full_force | (stall_en && $urandom_range(0, 3) == 0);
  end
  // monitor / scoreboard
  always @(negedge clk) begin
    logic [DATA_W:0] e;
    logic [CNT_W:0] d;
    sg = m_src_getn0;
    sr = m_reset0;
    if (rst_n) begin
      if (!m_src_getn0) begin
        pops++;
        chk("pop_with_push", m_dst_putn0, 1);
        chk("pop_while_full", m_dst_full0, 0);
        chk("pop_while_empty", m_src_empty0, 0);
      end
      if (!m_dst_putn0) begin
        chk("push_while_full", m_dst_full0, 0);
        if (expq.size() == 0) chk("unexpected_push", 1, 0);
        else begin
          e = expq.pop_front();
          chk("dst_data", m_dst0, e[DATA_W-1:0]);
          chk("dst_last", m_dst_last0, e[DATA_W]);
        end
      end
      if (done) begin
        dones++;
        if (doneq.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          d = doneq.pop_front();
          chk("done_word_cnt", word_cnt, d[CNT_W-1:0]);
          chk("done_ovf", ovf, d[CNT_W]);
          chk("done_busy", busy, 1);
        end
      end
    end
  end
  // reference: copy words until the src last flag or the word limit, whichever comes first
  task automatic expect_xfer(input bit inv_i, input logic [CNT_W-1:0] maxw);
    int lmt = (maxw == 0) ? (1 << CNT_W) - 1 : int'(maxw);
    int k = 0;
    bit seen_last = 0;
    foreach (stim_q[i]) begin
      if (seen_last || k == lmt) break;
      k++;
      seen_last = stim_q[i][DATA_W];
      expq.push_back({seen_last || k == lmt,
                      inv_i ? ~stim_q[i][DATA_W-1:0] : stim_q[i][DATA_W-1:0]});
    end
    doneq.push_back({!seen_last, CNT_W'(k)});
  endtask
  task automatic start_xfer(input bit inv_i, input logic [CNT_W-1:0] maxw);
    @(posedge clk); #2;
    start = 1; inv = inv_i; max_words = maxw;
    @(posedge clk); #2;
    start = 0; inv = $urandom_range(0, 1); max_words = CNT_W'($urandom);
    @(negedge clk);
    chk("start_m_reset0", m_reset0, 1);
    chk("start_busy", busy, 1);
    @(posedge clk); #2;
    foreach (stim_q[i]) srcq.push_back(stim_q[i]);
    m_src_empty0 = srcq.size() == 0;
  endtask
  task automatic wait_done(input int d0);
    for (int i = 0; i < 3000 && dones == d0; i++) @(posedge clk);
    chk("done_seen", dones > d0, 1);
    repeat (3) @(posedge clk);
    chk("done_once", dones - d0, 1);
    chk("exp_drained", expq.size(), 0);
    chk("idle_after", busy, 0);
  endtask
  task automatic run_xfer(input bit inv_i, input logic [CNT_W-1:0] maxw);
    int d0 = dones;
    expect_xfer(inv_i, maxw);
    start_xfer(inv_i, maxw);
    wait_done(d0);
  endtask
  task automatic wait_pops(input int target);
    for (int i = 0; i < 1000 && pops < target; i++) @(posedge clk);
    chk("pop_reached", pops >= target, 1);
  endtask
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_ovf"}, ovf, 0);
    chk({tag, "_word_cnt"}, word_cnt, 0);
    chk({tag, "_m_reset0"}, m_reset0, 0);
    chk({tag, "_getn"}, m_src_getn0, 1);
    chk({tag, "_putn"}, m_dst_putn0, 1);
    chk({tag, "_dst0"}, m_dst0, 0);
    chk({tag, "_dst_last"}, m_dst_last0, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end
  initial begin
    int d0, p0, n, p;
    bit has_last;
    logic [CNT_W-1:0] mw;
    repeat (3) @(posedge clk);
    check_reset_outputs("reset");
    #2 rst_n = 1;
    repeat (2) @(posedge clk);
    // 4 plain words, last on the 4th
    stim_q.delete();
    for (int i = 1; i <= 4; i++) stim_q.push_back({i == 4, 64'(i)});
    run_xfer(0, 0);
    // single inverted word
    stim_q.delete();
    stim_q.push_back({1'b1, 64'h00FF00FF00FF00FF});
    run_xfer(1, 0);
    // limit of 2 with no last: forced last and sticky overflow
    stim_q.delete();
    for (int i = 0; i < 5; i++) stim_q.push_back({1'b0, 64'hA5A5_0000_0000_0000 + 64'(i)});
    run_xfer(0, 2);
    // dst full held through WR
    stim_q.delete();
    stim_q.push_back({1'b1, 64'h1234_5678_9ABC_DEF0});
    d0 = dones; p0 = pops;
    expect_xfer(0, 0);
    start_xfer(0, 0);
    wait_pops(p0 + 1);
    #1 full_force = 1;
    p0 = pops;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk("full_putn_held", m_dst_putn0, 1);
    end
    chk("full_no_extra_pop", pops - p0, 0);
    @(posedge clk); #1 full_force = 0;
    @(negedge clk);
    chk("push_after_full", m_dst_putn0, 0);
    wait_done(d0);
    // abort in LAT after the third pop
    stim_q.delete();
    for (int i = 0; i < 5; i++) stim_q.push_back({1'b0, 64'hC0DE_0000_0000_0000 + 64'(i)});
    expq.push_back({1'b0, stim_q[0][DATA_W-1:0]});
    expq.push_back({1'b0, stim_q[1][DATA_W-1:0]});
    d0 = dones; p0 = pops;
    start_xfer(0, 0);
    wait_pops(p0 + 3);
    #2 abort = 1;
    @(posedge clk); #2 abort = 0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_m_reset0", m_reset0, 1);
    chk("abort_word_cnt", word_cnt, 2);
    @(negedge clk);
    chk("abort_m_reset0_end", m_reset0, 0);
    chk("abort_word_cnt_held", word_cnt, 2);
    repeat (3) @(posedge clk);
    chk("abort_no_done", dones - d0, 0);
    chk("abort_exp_drained", expq.size(), 0);
    // randomized transfers with random dst back-pressure
    stall_en = 1;
    for (int t = 0; t < 14; t++) begin
      stim_q.delete();
      n = $urandom_range(1, 8);
      has_last = 1'($urandom_range(0, 1));
      p = $urandom_range(0, n - 1);
      for (int i = 0; i < n; i++) stim_q.push_back({has_last && i == p, $urandom, $urandom});
      mw = has_last ? (($urandom_range(0, 2) == 0) ? '0 : CNT_W'($urandom_range(1, 10)))
                    : CNT_W'($urandom_range(1, n));
      run_xfer(1'($urandom_range(0, 1)), mw);
    end
    stall_en = 0;
    // async reset while stalled in WR
    stim_q.delete();
    stim_q.push_back({1'b0, 64'hDEAD_BEEF_0000_0001});
    stim_q.push_back({1'b1, 64'hDEAD_BEEF_0000_0002});
    p0 = pops;
    start_xfer(1, 1);
    wait_pops(p0 + 1);
    #1 full_force = 1;
    repeat (3) @(posedge clk);
    #3 rst_n = 0;
    #1 check_reset_outputs("async_rst");
    full_force = 0;
    expq.delete(); doneq.delete(); srcq.delete();
    @(posedge clk); #2 rst_n = 1;
    repeat (3) @(negedge clk);
    chk("post_rst_putn", m_dst_putn0, 1);
    chk("post_rst_busy", busy, 0);
    // a later transfer still works
    stim_q.delete();
    for (int i = 0; i < 3; i++) stim_q.push_back({i == 2, $urandom, $urandom});
    run_xfer(0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
